lpc_reg_bank: RTL and testbench

//  CPLD register file directly downstream of the LPC slave. It consumes the slave's decoded I/O strobes (addr, wdata, write, read, en).
//  It returns read data on o_lpc_rdata, which feeds the slave's i_lpc_rdata input.
//  It holds version, scratch, control, sticky event status with IRQ, and an 8-deep POST-code FIFO (BIOS port-80 style capture).

---
 rtl/lpc_reg_bank_pkg.sv | 30 +++
 rtl/lpc_reg_bank_post_fifo.sv | 63 ++++++
 rtl/lpc_reg_bank.sv | 118 +++++++++++
 tb/tb_lpc_reg_bank.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_reg_bank_pkg.sv
// Shared register offsets, POST_STAT layout and default version for the LPC register bank.
package lpc_reg_bank_pkg;

  localparam logic [7:0] CPLD_VERSION_DEF = 8'h16;

  localparam logic [7:0] REG_VERSION   = 8'h00;
  localparam logic [7:0] REG_SCRATCH   = 8'h01;
  localparam logic [7:0] REG_CTRL      = 8'h02;
  localparam logic [7:0] REG_STATUS    = 8'h03;
  localparam logic [7:0] REG_POST_DATA = 8'h04;
  localparam logic [7:0] REG_POST_STAT = 8'h05;
  localparam logic [7:0] REG_POST_LAST = 8'h06;
  localparam logic [7:0] REG_IRQ_MASK  = 8'h07;

  localparam logic [7:0] RD_UNMAPPED = 8'hFF;

  localparam int POST_STAT_EMPTY_BIT = 7;
  localparam int POST_STAT_OVF_BIT   = 6;

  function automatic logic [7:0] post_stat_pack(input logic empty, input logic ovf,
                                                input logic [4:0] count);
    logic [7:0] s;
    s = '0;
    s[POST_STAT_EMPTY_BIT] = empty;
    s[POST_STAT_OVF_BIT]   = ovf;
    s[4:0]                 = count;
    return s;
  endfunction

endpackage

// File: rtl/lpc_reg_bank_post_fifo.sv
// POST-code FIFO: register-array storage, head entry presented combinationally.
module lpc_reg_bank_post_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic [4:0]    count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == 5'(DEPTH));
  assign empty_o = (count_q == 5'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 5'd1;
    end else if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/lpc_reg_bank.sv
// CPLD register file behind the LPC slave: decode, sticky events with IRQ, POST-code capture.
module lpc_reg_bank
  import lpc_reg_bank_pkg::*;
#(
  parameter logic [7:0] CPLD_VERSION = CPLD_VERSION_DEF,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         NUM_EVT      = 8
) (
  input  logic               i_LPCClk,
  input  logic               i_rst_n,
  input  logic [7:0]         i_lpc_addr,
  input  logic [7:0]         i_lpc_wdata,
  input  logic               i_lpc_write,
  input  logic               i_lpc_read,
  input  logic               i_lpc_en,
  output logic [7:0]         o_lpc_rdata,
  input  logic [NUM_EVT-1:0] i_evt,
  output logic [7:0]         o_ctrl,
  output logic               o_irq,
  output logic [7:0]         o_post_code
);

  logic               wr, rd, push, pop;
  logic [7:0]         scratch_q, scratch_d, ctrl_q, ctrl_d, last_q, last_d;
  logic [NUM_EVT-1:0] status_q, status_d, mask_q, mask_d, status_clr;
  logic               ovf_q, ovf_d, irq_q, irq_d;
  logic [7:0]         fifo_dout;
  logic [4:0]         fifo_count;
  logic               fifo_full, fifo_empty;
  logic [7:0]         status_rd, mask_rd;

  // A simultaneous write and read is treated as a write only.
  assign wr   = i_lpc_write & i_lpc_en;
  assign rd   = i_lpc_read & i_lpc_en & ~wr;
  assign push = wr && (i_lpc_addr == REG_POST_DATA);
  assign pop  = rd && (i_lpc_addr == REG_POST_DATA);

  lpc_reg_bank_post_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_post_fifo (
    .clk_i   (i_LPCClk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (i_lpc_wdata),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    scratch_d  = scratch_q;
    ctrl_d     = ctrl_q;
    mask_d     = mask_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    status_clr = '0;
    if (wr) begin
      case (i_lpc_addr)
        REG_SCRATCH:   scratch_d = i_lpc_wdata;
        REG_CTRL:      ctrl_d = i_lpc_wdata;
        REG_STATUS:    status_clr = i_lpc_wdata[NUM_EVT-1:0];
        REG_POST_DATA: begin
          last_d = i_lpc_wdata;
          if (fifo_full) ovf_d = 1'b1;
        end
        REG_POST_STAT: if (i_lpc_wdata[POST_STAT_OVF_BIT]) ovf_d = 1'b0;
        REG_IRQ_MASK:  mask_d = i_lpc_wdata[NUM_EVT-1:0];
        default:       ;
      endcase
    end
    // Event set is applied after the clear so a same-cycle event survives W1C.
    status_d = (status_q & ~status_clr) | i_evt;
    irq_d    = |(status_q & mask_q);
  end

  always_ff @(posedge i_LPCClk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      last_q    <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      last_q    <= last_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    status_rd = '0;
    mask_rd   = '0;
    status_rd[NUM_EVT-1:0] = status_q;
    mask_rd[NUM_EVT-1:0]   = mask_q;
    case (i_lpc_addr)
      REG_VERSION:   o_lpc_rdata = CPLD_VERSION;
      REG_SCRATCH:   o_lpc_rdata = scratch_q;
      REG_CTRL:      o_lpc_rdata = ctrl_q;
      REG_STATUS:    o_lpc_rdata = status_rd;
      REG_POST_DATA: o_lpc_rdata = fifo_empty ? 8'h00 : fifo_dout;
      REG_POST_STAT: o_lpc_rdata = post_stat_pack(fifo_empty, ovf_q, fifo_count);
      REG_POST_LAST: o_lpc_rdata = last_q;
      REG_IRQ_MASK:  o_lpc_rdata = mask_rd;
      default:       o_lpc_rdata = RD_UNMAPPED;
    endcase
  end

  assign o_ctrl      = ctrl_q;
  assign o_irq       = irq_q;
  assign o_post_code = last_q;

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Scoreboard bench for lpc_reg_bank: stimulus queues expectations, a negedge monitor checks them.
module tb_lpc_reg_bank;

  localparam int K_RD   = 0;
  localparam int K_CTRL = 1;
  localparam int K_IRQ  = 2;
  localparam int K_POST = 3;

  typedef struct {
    int         kind;
    logic [7:0] exp;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] addr, wdata, rdata, ctrl, post_code, evt;
  logic       write, read, en, irq;
  logic       chk_req = 1'b0;
  logic       fin_req = 1'b0;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] mon_act;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  lpc_reg_bank #(.CPLD_VERSION(8'h16), .FIFO_DEPTH(8), .NUM_EVT(8)) dut (
    .i_LPCClk    (clk),
    .i_rst_n     (rst_n),
    .i_lpc_addr  (addr),
    .i_lpc_wdata (wdata),
    .i_lpc_write (write),
    .i_lpc_read  (read),
    .i_lpc_en    (en),
    .o_lpc_rdata (rdata),
    .i_evt       (evt),
    .o_ctrl      (ctrl),
    .o_irq       (irq),
    .o_post_code (post_code)
  );

  // Monitor: a qualified read strobe or a probe request consumes one expectation.
  always @(negedge clk) begin
    if ((read && en && !write) || chk_req) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_sample: got rdata=%02h with no expectation queued", rdata);
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.kind)
          K_CTRL:  mon_act = ctrl;
          K_IRQ:   mon_act = {7'd0, irq};
          K_POST:  mon_act = post_code;
          default: mon_act = rdata;
        endcase
        if (mon_act !== mon_e.exp) begin
          bad++;
          $display("FAIL %s: got %02h expected %02h", mon_e.name, mon_act, mon_e.exp);
        end else begin
          $display("ok   %s: %02h", mon_e.name, mon_act);
        end
      end
    end
    if (fin_req) begin
      total++;
      if (sb_q.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d pending expectations expected 0", sb_q.size());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d, input logic e = 1'b1);
    addr = a; wdata = d; write = 1'b1; en = e;
    cyc();
    write = 1'b0; en = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, input logic [7:0] exp, input string nm);
    sb_q.push_back('{K_RD, exp, nm});
    addr = a; read = 1'b1; en = 1'b1;
    cyc();
    read = 1'b0; en = 1'b0;
  endtask

  task automatic chk(input int k, input logic [7:0] exp, input string nm);
    sb_q.push_back('{k, exp, nm});
    chk_req = 1'b1;
    cyc();
    chk_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; wdata = '0; write = 1'b0; read = 1'b0; en = 1'b0; evt = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Reset state and fixed reads
    rd_reg(8'h00, 8'h16, "version");
    rd_reg(8'h05, 8'h80, "post_stat_reset");
    rd_reg(8'h20, 8'hFF, "unmapped_read");
    chk(K_CTRL, 8'h00, "ctrl_reset");
    chk(K_IRQ, 8'h00, "irq_reset");
    chk(K_POST, 8'h00, "post_code_reset");

    // Scratch, ctrl, enable qualification, ignored writes
    wr_reg(8'h01, 8'h5A);
    rd_reg(8'h01, 8'h5A, "scratch_rw");
    wr_reg(8'h02, 8'hC3);
    chk(K_CTRL, 8'hC3, "ctrl_out");
    rd_reg(8'h02, 8'hC3, "ctrl_read");
    wr_reg(8'h01, 8'hFF, 1'b0);
    rd_reg(8'h01, 8'h5A, "scratch_en0");
    wr_reg(8'h20, 8'hAA);
    rd_reg(8'h20, 8'hFF, "unmapped_write");
    wr_reg(8'h00, 8'hAA);
    rd_reg(8'h00, 8'h16, "version_ro");

    // FIFO basic push/pop
    wr_reg(8'h04, 8'h11);
    wr_reg(8'h04, 8'h22);
    wr_reg(8'h04, 8'h33);
    rd_reg(8'h05, 8'h03, "post_stat_3");
    rd_reg(8'h06, 8'h33, "post_last");
    chk(K_POST, 8'h33, "post_code_out");
    rd_reg(8'h04, 8'h11, "pop_1");
    rd_reg(8'h04, 8'h22, "pop_2");
    rd_reg(8'h04, 8'h33, "pop_3");
    rd_reg(8'h05, 8'h80, "post_stat_empty");
    rd_reg(8'h04, 8'h00, "pop_empty");
    rd_reg(8'h05, 8'h80, "post_stat_after_empty_pop");

    // Write and read together: the push happens, the pop does not
    addr = 8'h04; wdata = 8'h99; write = 1'b1; read = 1'b1; en = 1'b1;
    cyc();
    write = 1'b0; read = 1'b0; en = 1'b0;
    rd_reg(8'h05, 8'h01, "wr_beats_rd_count");
    rd_reg(8'h04, 8'h99, "wr_beats_rd_data");
    rd_reg(8'h05, 8'h80, "wr_beats_rd_empty");

    // Overflow
    for (int i = 1; i <= 9; i++) wr_reg(8'h04, 8'(i));
    rd_reg(8'h05, 8'h48, "post_stat_ovf");
    rd_reg(8'h06, 8'h09, "post_last_ovf");
    for (int i = 1; i <= 8; i++) rd_reg(8'h04, 8'(i), $sformatf("ovf_pop_%0d", i));
    rd_reg(8'h05, 8'hC0, "post_stat_empty_ovf");
    wr_reg(8'h05, 8'h00);
    rd_reg(8'h05, 8'hC0, "ovf_kept_on_w0");
    wr_reg(8'h05, 8'h40);
    rd_reg(8'h05, 8'h80, "ovf_cleared");

    // Sticky status and IRQ timing
    wr_reg(8'h07, 8'h01);
    rd_reg(8'h07, 8'h01, "mask_rw");
    evt = 8'h01;
    cyc();
    evt = 8'h00;
    chk(K_IRQ, 8'h00, "irq_not_yet");
    rd_reg(8'h03, 8'h01, "status_sticky");
    chk(K_IRQ, 8'h01, "irq_rise");
    evt = 8'h01;
    wr_reg(8'h03, 8'h01);
    rd_reg(8'h03, 8'h01, "set_beats_clear");
    chk(K_IRQ, 8'h01, "irq_held");
    evt = 8'h00;
    wr_reg(8'h03, 8'h01);
    chk(K_IRQ, 8'h01, "irq_fall_lag");
    chk(K_IRQ, 8'h00, "irq_fall");
    rd_reg(8'h03, 8'h00, "status_cleared");
    evt = 8'h02;
    cyc();
    evt = 8'h00;
    cyc();
    chk(K_IRQ, 8'h00, "irq_masked");
    rd_reg(8'h03, 8'h02, "status_bit1");
    wr_reg(8'h07, 8'h03);
    chk(K_IRQ, 8'h00, "irq_unmask_lag");
    chk(K_IRQ, 8'h01, "irq_unmasked");
    wr_reg(8'h07, 8'h00);
    chk(K_IRQ, 8'h01, "irq_mask_lag");
    chk(K_IRQ, 8'h00, "irq_masked_off");

    // Reset in the middle of a push sequence
    wr_reg(8'h07, 8'h02);
    wr_reg(8'h04, 8'hA1);
    wr_reg(8'h04, 8'hA2);
    wr_reg(8'h04, 8'hA3);
    chk(K_IRQ, 8'h01, "irq_before_reset");
    rd_reg(8'h05, 8'h03, "count_before_reset");
    rst_n = 1'b0;
    chk(K_POST, 8'h00, "post_code_in_reset");
    chk(K_IRQ, 8'h00, "irq_in_reset");
    rd_reg(8'h05, 8'h80, "post_stat_in_reset");
    rd_reg(8'h03, 8'h00, "status_in_reset");
    rd_reg(8'h07, 8'h00, "mask_in_reset");
    chk(K_CTRL, 8'h00, "ctrl_in_reset");
    rst_n = 1'b1;
    cyc();
    wr_reg(8'h04, 8'h77);
    rd_reg(8'h05, 8'h01, "post_stat_after_reset");
    rd_reg(8'h06, 8'h77, "post_last_after_reset");
    rd_reg(8'h04, 8'h77, "pop_after_reset");
    rd_reg(8'h05, 8'h80, "empty_after_reset");

    fin_req = 1'b1;
    @(negedge clk);
    #1;
    fin_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
